regfile_wb_arbiter: RTL and testbench

//   Shares the single register-file write port between two writeback requesters:
//   ALU (requester 0) and load/store unit (requester 1).

---
 rtl/regfile_wb_arbiter_pkg.sv | 8 +
 rtl/regfile_wb_arbiter_arb.sv | 27 ++
 rtl/regfile_wb_arbiter.sv | 60 ++++++
 tb/tb_regfile_wb_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: register-file writeback constants shared with the RISC-V core headers
package regfile_wb_arbiter_pkg;
    localparam int XLEN = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic WB_REQ_ALU = 1'b0;
    localparam logic WB_REQ_LSU = 1'b1;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_wb_arbiter_arb.sv
// wb_rr_arbiter: 2-way writeback grant logic and last_grant register.
// WB_ARB_RR_EN selects round-robin; otherwise the ALU has fixed priority.
module wb_rr_arbiter
    import regfile_wb_arbiter_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic hold,
    input  logic alu_valid,
    input  logic lsu_valid,
    output logic alu_grant,
    output logic lsu_grant,
    output logic last_grant
);
    logic open;
    assign open = !reset && !hold;
`ifdef WB_ARB_RR_EN
    assign alu_grant = open && alu_valid && (!lsu_valid || last_grant == WB_REQ_LSU);
    assign lsu_grant = open && lsu_valid && (!alu_valid || last_grant == WB_REQ_ALU);
`else
    assign alu_grant = open && alu_valid;
    assign lsu_grant = open && lsu_valid && !alu_valid;
`endif
    always_ff @(posedge clock or posedge reset)
        if (reset) last_grant <= WB_REQ_LSU;
        else if (alu_grant || lsu_grant) last_grant <= lsu_grant ? WB_REQ_LSU : WB_REQ_ALU;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between ALU and LSU writeback.
// Optional round-robin arbitration via WB_ARB_RR_EN (fixed ALU priority otherwise).
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int XLEN  = regfile_wb_arbiter_pkg::XLEN,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [4:0]       alu_rd,
    input  logic [XLEN-1:0]  alu_data,
    input  logic             lsu_valid,
    output logic             lsu_ready,
    input  logic [4:0]       lsu_rd,
    input  logic [XLEN-1:0]  lsu_data,
    input  logic             rf_hold,
    output logic             RegWrite,
    output logic [4:0]       Write_register,
    output logic [XLEN-1:0]  Write_data,
    output logic             last_grant,
    output logic [CNT_W-1:0] conflict_cnt
);
    logic xfer;
    reg_addr_t sel_rd;
    logic [XLEN-1:0] sel_data;
    wb_rr_arbiter u_arb (
        .clock      (clock),
        .reset      (reset),
        .hold       (rf_hold),
        .alu_valid  (alu_valid),
        .lsu_valid  (lsu_valid),
        .alu_grant  (alu_ready),
        .lsu_grant  (lsu_ready),
        .last_grant (last_grant)
    );
    always_comb begin
        xfer     = alu_ready || lsu_ready;
        sel_rd   = lsu_ready ? lsu_rd : alu_rd;
        sel_data = lsu_ready ? lsu_data : alu_data;
    end
    // x0 writes are accepted but never raise RegWrite
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            RegWrite       <= 1'b0;
            Write_register <= '0;
            Write_data     <= '0;
            conflict_cnt   <= '0;
        end else begin
            RegWrite <= xfer && sel_rd != '0;
            if (xfer) begin
                Write_register <= sel_rd;
                Write_data     <= sel_data;
            end
            if (alu_valid && lsu_valid && !rf_hold && conflict_cnt != '1)
                conflict_cnt <= conflict_cnt + 1'b1;
        end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scoreboard bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;
    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic        clock = 0;
    logic        reset = 0;
    logic        alu_valid = 0, lsu_valid = 0, rf_hold = 0;
    logic [4:0]  alu_rd = 0, lsu_rd = 0;
    logic [31:0] alu_data = 0, lsu_data = 0;
    logic        alu_ready, lsu_ready, RegWrite, last_grant;
    logic [4:0]  Write_register;
    logic [31:0] Write_data;
    logic [15:0] conflict_cnt;

    int passed = 0;
    int total = 0;
    wr_t q[$];
    logic        m_last = 1;
    logic [15:0] m_cnt = 0;
    logic [4:0]  m_wreg = 0;
    logic [31:0] m_wdata = 0;

    regfile_wb_arbiter #(.XLEN(32), .CNT_W(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .lsu_valid      (lsu_valid),
        .lsu_ready      (lsu_ready),
        .lsu_rd         (lsu_rd),
        .lsu_data       (lsu_data),
        .rf_hold        (rf_hold),
        .RegWrite       (RegWrite),
        .Write_register (Write_register),
        .Write_data     (Write_data),
        .last_grant     (last_grant),
        .conflict_cnt   (conflict_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic cycle();
        logic ga, gl;
        wr_t e;
        #1;
        ga = 0;
        gl = 0;
        if (!rf_hold) begin
`ifdef WB_ARB_RR_EN
            ga = alu_valid && (!lsu_valid || m_last);
            gl = lsu_valid && (!alu_valid || !m_last);
`else
            ga = alu_valid;
            gl = lsu_valid && !alu_valid;
`endif
        end
        check("alu_ready", alu_ready, ga);
        check("lsu_ready", lsu_ready, gl);
        e.we = 0;
        if (ga || gl) begin
            m_wreg  = gl ? lsu_rd : alu_rd;
            m_wdata = gl ? lsu_data : alu_data;
            e.we    = m_wreg != 0;
            m_last  = gl;
        end
        e.rd = m_wreg;
        e.data = m_wdata;
        q.push_back(e);
        if (alu_valid && lsu_valid && !rf_hold && m_cnt != 16'hFFFF) m_cnt++;
        @(posedge clock);
        #1;
        e = q.pop_front();
        check("RegWrite", RegWrite, e.we);
        check("Write_register", Write_register, e.rd);
        check("Write_data", Write_data, e.data);
        check("conflict_cnt", conflict_cnt, m_cnt);
        check("last_grant", last_grant, m_last);
    endtask

    task automatic do_reset();
        reset = 1;
        #1;
        check("rst_RegWrite", RegWrite, 0);
        check("rst_Write_register", Write_register, 0);
        check("rst_Write_data", Write_data, 0);
        check("rst_conflict_cnt", conflict_cnt, 0);
        check("rst_alu_ready", alu_ready, 0);
        check("rst_lsu_ready", lsu_ready, 0);
        check("rst_last_grant", last_grant, 1);
        @(posedge clock);
        #1;
        reset = 0;
        m_last = 1;
        m_cnt = 0;
        m_wreg = 0;
        m_wdata = 0;
        q.delete();
    endtask

    initial begin
        @(posedge clock);
        #1;
        do_reset();
        // single ALU write, then idle
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        cycle();
        check("t1_we", RegWrite, 1);
        check("t1_rd", Write_register, 5);
        check("t1_data", Write_data, 32'hDEADBEEF);
        alu_valid = 0;
        cycle();
        check("t1_we_off", RegWrite, 0);
        // four-cycle conflict straight after reset
        do_reset();
        alu_valid = 1; alu_rd = 1; alu_data = 32'hA0000001;
        lsu_valid = 1; lsu_rd = 2; lsu_data = 32'hB0000002;
        for (int i = 0; i < 4; i++) cycle();
        check("t2_cnt", conflict_cnt, 4);
        alu_valid = 0; lsu_valid = 0;
        cycle();
        // x0 write from LSU
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h1234;
        cycle();
        check("t3_we", RegWrite, 0);
        check("t3_rd", Write_register, 0);
        lsu_valid = 0;
        cycle();
        // hold blocks grants, then releases one write
        rf_hold = 1; alu_valid = 1; alu_rd = 7; alu_data = 32'h77770007;
        for (int i = 0; i < 3; i++) cycle();
        rf_hold = 0;
        cycle();
        check("t4_we", RegWrite, 1);
        check("t4_rd", Write_register, 7);
        alu_valid = 0;
        cycle();
        // async reset while a write is on the port
        alu_valid = 1; alu_rd = 9; alu_data = 32'hCAFE0009;
        cycle();
        check("t5_pre_we", RegWrite, 1);
        lsu_valid = 1; lsu_rd = 3; lsu_data = 32'h3;
        do_reset();
        alu_valid = 0; lsu_valid = 0;
        cycle();
        // counter saturation
        alu_valid = 1; alu_rd = 1; lsu_valid = 1; lsu_rd = 2;
        for (int i = 0; i < 65539; i++) cycle();
        check("t6_sat", conflict_cnt, 16'hFFFF);
        alu_valid = 0; lsu_valid = 0;
        cycle();
        check("t6_hold", conflict_cnt, 16'hFFFF);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
